// File: rtl/fryer_matrix_sequencer.sv
// Cook-cycle controller for the air fryer. Turns the debounced start, pause
// and cancel pulses into a four-state cook FSM and runs the countdown timer.
// It also produces the scan row, animation frame, colour mode and matrix
// enable, all registered, so the matrix driver is pure combinational decode.
module fryer_matrix_sequencer #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int TW            = 10,
  parameter int BLINK_SECS    = 3
) (
  input  logic          clk_1Khz,
  input  logic          rst,
  input  logic          start_btn,
  input  logic          pause_btn,
  input  logic          cancel_btn,
  input  logic [1:0]    mode_sel,
  input  logic [TW-1:0] cook_secs,
  output logic [1:0]    state_o,
  output logic [1:0]    mode_o,
  output logic [1:0]    frame_idx,
  output logic [2:0]    row_idx,
  output logic          matrix_en,
  output logic [TW-1:0] remain_secs,
  output logic          done_pulse
);

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_WORK  = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  localparam int TICK_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int BLINK_W = (BLINK_SECS > 1) ? $clog2(BLINK_SECS) : 1;

  localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [TICK_W-1:0]  TICK_HALF  = TICK_W'(TICKS_PER_SEC / 2);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_SECS - 1);

  logic [TICK_W-1:0]  tick_cnt, tick_d, tick_adv;
  logic [BLINK_W-1:0] blink_cnt, blink_d;
  logic [1:0]         state_d, mode_d, frame_d;
  logic [TW-1:0]      remain_d;
  logic               en_d, pulse_d;
  logic               sec_evt;
  logic               start_eff, pause_eff;

  // Button priority is global: a higher-priority pulse masks the lower ones
  // even in states where it has no effect of its own.
  assign pause_eff = pause_btn & ~cancel_btn;
  assign start_eff = start_btn & ~pause_btn & ~cancel_btn;

  assign sec_evt  = (tick_cnt == TICK_LAST);
  assign tick_adv = sec_evt ? '0 : tick_cnt + TICK_W'(1);

  // Next-state and next-output decode for the cook FSM and its timers.
  always_comb begin
    // NOTE: every variable gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    state_d  = state_o;
    mode_d   = mode_o;
    frame_d  = frame_idx;
    remain_d = remain_secs;
    tick_d   = tick_cnt;
    blink_d  = blink_cnt;
    pulse_d  = 1'b0;

    case (state_o)
      S_IDLE: begin
        if (start_eff && (cook_secs != '0) && (mode_sel != 2'b00)) begin
          state_d  = S_WORK;
          mode_d   = mode_sel;
          remain_d = cook_secs;
          tick_d   = '0;
          frame_d  = 2'd0;
        end
      end

      S_WORK: begin
        if (cancel_btn) begin
          state_d = S_IDLE;
        end else if (pause_eff) begin
          // Tick counter holds: a coincident sec_evt is dropped.
          state_d = S_PAUSE;
        end else begin
          tick_d = tick_adv;
          if (sec_evt) begin
            if (remain_secs <= TW'(1)) begin
              // Last second: never underflow, go straight to the blink phase.
              remain_d = '0;
              state_d  = S_DONE;
              pulse_d  = 1'b1;
              frame_d  = 2'd3;
              blink_d  = '0;
            end else begin
              remain_d = remain_secs - TW'(1);
              frame_d  = frame_idx + 2'd1;
            end
          end
        end
      end

      S_PAUSE: begin
        if (cancel_btn) begin
          state_d = S_IDLE;
        end else if (pause_eff || start_eff) begin
          state_d = S_WORK;
        end
      end

      default: begin // S_DONE
        if (cancel_btn || start_eff) begin
          state_d = S_IDLE;
        end else begin
          tick_d  = tick_adv;
          frame_d = 2'd3;
          if (sec_evt) begin
            if (blink_cnt == BLINK_LAST) begin
              state_d = S_IDLE;
            end else begin
              blink_d = blink_cnt + BLINK_W'(1);
            end
          end
        end
      end
    endcase

    // Leaving for IDLE from any state clears everything the matrix sees.
    if (state_d == S_IDLE) begin
      mode_d   = 2'b00;
      frame_d  = 2'd0;
      remain_d = '0;
      tick_d   = '0;
      blink_d  = '0;
    end

    // Enable follows the state being entered; DONE blinks at 1 Hz.
    en_d = (state_d != S_IDLE) && !((state_d == S_DONE) && (tick_d >= TICK_HALF));
  end

  // Register the FSM, timers and all outputs.
  always_ff @(posedge clk_1Khz or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst) begin
      state_o     <= S_IDLE;
      mode_o      <= 2'b00;
      frame_idx   <= 2'd0;
      row_idx     <= 3'd0;
      matrix_en   <= 1'b0;
      remain_secs <= '0;
      done_pulse  <= 1'b0;
      tick_cnt    <= '0;
      blink_cnt   <= '0;
    end else begin
      state_o     <= state_d;
      mode_o      <= mode_d;
      frame_idx   <= frame_d;
      row_idx     <= row_idx + 3'd1;
      matrix_en   <= en_d;
      remain_secs <= remain_d;
      done_pulse  <= pulse_d;
      tick_cnt    <= tick_d;
      blink_cnt   <= blink_d;
    end
  end

endmodule

// File: tb/tb_fryer_matrix_sequencer.sv
// Bench for fryer_matrix_sequencer: directed scenarios followed by random
// button traffic, every cycle compared against an elapsed-time reference model.
module tb_fryer_matrix_sequencer;

  localparam int TPS   = 10;
  localparam int TW    = 10;
  localparam int BLINK = 3;

  logic          clk_1Khz = 1'b0;
  logic          rst = 1'b0;
  logic          start_btn = 1'b0, pause_btn = 1'b0, cancel_btn = 1'b0;
  logic [1:0]    mode_sel = 2'b00;
  logic [TW-1:0] cook_secs = '0;
  logic [1:0]    state_o, mode_o, frame_idx;
  logic [2:0]    row_idx;
  logic          matrix_en, done_pulse;
  logic [TW-1:0] remain_secs;

  fryer_matrix_sequencer #(.TICKS_PER_SEC(TPS), .TW(TW), .BLINK_SECS(BLINK)) dut (
    .clk_1Khz   (clk_1Khz),
    .rst        (rst),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .cancel_btn (cancel_btn),
    .mode_sel   (mode_sel),
    .cook_secs  (cook_secs),
    .state_o    (state_o),
    .mode_o     (mode_o),
    .frame_idx  (frame_idx),
    .row_idx    (row_idx),
    .matrix_en  (matrix_en),
    .remain_secs(remain_secs),
    .done_pulse (done_pulse)
  );

  always #5 clk_1Khz = ~clk_1Khz;

  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, n_cycle, got, exp);
    end
  endtask

  // Reference model: tracks elapsed cooking cycles and elapsed blink cycles;
  // remaining time, frame and blink phase are derived by division.
  typedef enum {M_IDLE, M_RUN, M_HOLD, M_BLINK} mphase_t;
  mphase_t ph;
  int      cook_m, mode_m, worked, blinked, row_m;
  bit      pulse_m;

  task automatic model_reset();
    ph = M_IDLE; cook_m = 0; mode_m = 0; worked = 0; blinked = 0;
    row_m = 0; pulse_m = 0;
  endtask

  task automatic model_step(input bit s, input bit p, input bit c,
                            input int m, input int ck);
    pulse_m = 0;
    row_m   = (row_m + 1) % 8;
    case (ph)
      M_IDLE:
        if (!c && !p && s && ck != 0 && m != 0) begin
          ph = M_RUN; cook_m = ck; mode_m = m; worked = 0;
        end
      M_RUN:
        if (c) ph = M_IDLE;
        else if (p) ph = M_HOLD;
        else begin
          worked++;
          if (worked == cook_m * TPS) begin
            ph = M_BLINK; blinked = 0; pulse_m = 1;
          end
        end
      M_HOLD:
        if (c) ph = M_IDLE;
        else if (p || s) ph = M_RUN;
      M_BLINK:
        if (c || (s && !p)) ph = M_IDLE;
        else begin
          blinked++;
          if (blinked == BLINK * TPS) ph = M_IDLE;
        end
    endcase
  endtask

  task automatic compare_all();
    int e_state, e_mode, e_frame, e_remain, e_en;
    case (ph)
      M_IDLE:  begin e_state = 0; e_mode = 0; e_frame = 0; e_remain = 0; e_en = 0; end
      M_RUN, M_HOLD: begin
        e_state  = (ph == M_RUN) ? 1 : 2;
        e_mode   = mode_m;
        e_frame  = (worked / TPS) % 4;
        e_remain = cook_m - worked / TPS;
        e_en     = 1;
      end
      default: begin
        e_state = 3; e_mode = mode_m; e_frame = 3; e_remain = 0;
        e_en    = ((blinked % TPS) < TPS / 2) ? 1 : 0;
      end
    endcase
    check("state",  32'(state_o),     32'(e_state));
    check("mode",   32'(mode_o),      32'(e_mode));
    check("frame",  32'(frame_idx),   32'(e_frame));
    check("remain", 32'(remain_secs), 32'(e_remain));
    check("en",     32'(matrix_en),   32'(e_en));
    check("pulse",  32'(done_pulse),  32'(pulse_m));
    check("row",    32'(row_idx),     32'(row_m));
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic cycle(input bit s, input bit p, input bit c, input int m, input int ck);
    start_btn = s; pause_btn = p; cancel_btn = c;
    mode_sel = 2'(m); cook_secs = TW'(ck);
    @(posedge clk_1Khz);
    n_cycle++;
    model_step(s, p, c, m, ck);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // Reset pulse placed between clock edges; outputs must clear at once.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    #2 rst = 1'b1;
  endtask

  int pulses;

  initial begin
    model_reset();
    #2;
    compare_all();
    #10 rst = 1'b1;

    // Full cook: 3 s at medium, then the 3 s blink back to idle.
    pulses = 0;
    cycle(1, 0, 0, 2, 3);
    check("start_state", 32'(state_o), 32'd1);
    for (int i = 0; i < 65; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (done_pulse) pulses++;
    end
    check("pulse_count", 32'(pulses), 32'd1);

    // Invalid starts are ignored.
    cycle(1, 0, 0, 0, 5);
    cycle(1, 0, 0, 2, 0);
    idle(2);

    // Pause at remain 5 / tick 4, hold 50 cycles, resume.
    cycle(1, 0, 0, 1, 6);
    idle(14);
    check("pre_pause_remain", 32'(remain_secs), 32'd5);
    cycle(0, 1, 0, 0, 0);
    idle(50);
    cycle(0, 1, 0, 0, 0);
    idle(20);
    cycle(0, 0, 1, 0, 0);

    // Pause landing exactly on a second boundary must not decrement.
    cycle(1, 0, 0, 3, 4);
    idle(9);
    cycle(0, 1, 0, 0, 0);
    check("pause_on_sec_remain", 32'(remain_secs), 32'd4);
    idle(5);
    cycle(0, 0, 1, 0, 0);

    // Cancel and pause together in WORK: cancel wins.
    cycle(1, 0, 0, 2, 2);
    idle(3);
    cycle(0, 1, 1, 0, 0);
    idle(2);

    // Reset in the middle of WORK.
    cycle(1, 0, 0, 3, 5);
    idle(7);
    async_reset();
    idle(5);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      cycle($urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 39) == 0, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 4)));
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    start_btn = 0; pause_btn = 0; cancel_btn = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fryer_matrix_sequencer.md
Name: fryer_matrix_sequencer

Overview:
Top-level cook-cycle controller for the air fryer; it sequences the two-colour dot-matrix display driver. It turns debounced start, pause and cancel pulses into a 4-state cook FSM and runs the countdown timer. It generates the matrix scan row index, the animation frame index, the latched colour/heat mode and the matrix enable, so the matrix driver becomes purely combinational decode.

Parameters:
TICKS_PER_SEC, 1000, clk_1Khz cycles per second (override to 10 in simulation)
TW, 10, width of the cook-time and remaining-time counters in seconds
BLINK_SECS, 3, duration of the DONE blink before returning to IDLE

Ports:
clk_1Khz  in  1  system clock, 1 kHz
rst  in  1  asynchronous, active-low reset
start_btn  in  1  one-cycle pulse, debounced upstream
pause_btn  in  1  one-cycle pulse, toggles pause
cancel_btn  in  1  one-cycle pulse, aborts the cook cycle
mode_sel  in  2  requested heat mode; 00 = none, 01/10/11 = low/med/high
cook_secs  in  TW  requested cook time in seconds
state_o  out  2  00 IDLE, 01 WORK, 10 PAUSE, 11 DONE
mode_o  out  2  mode latched at start; drives matrix colour select
frame_idx  out  2  animation frame, 0..3
row_idx  out  3  scan row, 0..7
matrix_en  out  1  matrix lighting enable
remain_secs  out  TW  seconds left in the cook cycle
done_pulse  out  1  one-cycle pulse when the countdown reaches 0

Behaviour:
- All outputs are registered. Every input causes its effect on the clock edge after it is sampled.
- Reset (rst = 0) immediately forces all outputs to 0, state to IDLE, the internal tick counter to 0 and the blink counter to 0.
- row_idx: increments every cycle in all states and wraps 7 -> 0. It is independent of the FSM.
- tick counter: 0..TICKS_PER_SEC-1. It advances only in WORK and DONE and holds in PAUSE.
- sec_evt: an internal signal, true in a cycle where the tick counter equals TICKS_PER_SEC-1. On that cycle the counter wraps to 0.
- Button priority within one cycle: cancel > pause > start.
- IDLE:
  - start_btn with cook_secs != 0 and mode_sel != 0 -> WORK. On the same edge: mode_o <= mode_sel, remain_secs <= cook_secs, tick counter <= 0, frame_idx <= 0.
  - start_btn with cook_secs == 0 or mode_sel == 0 is ignored.
  - pause_btn and cancel_btn have no effect.
  - Outputs in IDLE: mode_o = 0, frame_idx = 0, remain_secs = 0, matrix_en = 0.
- WORK:
  - matrix_en = 1.
  - On sec_evt: remain_secs decrements by 1 and frame_idx increments, wrapping 3 -> 0.
  - If remain_secs == 1 on sec_evt: remain_secs <= 0, state <= DONE, done_pulse = 1 for exactly that transition cycle.
  - pause_btn -> PAUSE. In that cycle the tick counter holds, with no decrement even if sec_evt would have fired.
  - cancel_btn -> IDLE; this also clears the outputs and suppresses any coincident sec_evt.
  - start_btn is ignored; cook_secs and mode_sel are not re-sampled.
- PAUSE:
  - matrix_en = 1. frame_idx, remain_secs and the tick counter are frozen.
  - pause_btn or start_btn -> WORK, resuming from the frozen tick count.
  - cancel_btn -> IDLE.
- DONE:
  - mode_o is held and frame_idx = 3 (full picture).
  - matrix_en = 1 while tick counter < TICKS_PER_SEC/2, otherwise 0 (1 Hz blink).
  - The blink counter counts sec_evt events. After BLINK_SECS of them -> IDLE.
  - start_btn or cancel_btn -> IDLE immediately.
  - A new cook cycle needs a fresh start_btn pulse in IDLE.
- Width rule: remain_secs never underflows below 0.
- Reset asserted mid-cycle from any state: outputs are cleared immediately and nothing resumes on release.

Test Plan:
- TICKS_PER_SEC = 10, reset, then start_btn with cook_secs = 3, mode_sel = 10:
  - next cycle: state_o = 01, mode_o = 10, remain_secs = 3, matrix_en = 1;
  - then every 10 cycles remain_secs steps 2, 1, 0 and frame_idx steps 1, 2, 3;
  - at 0: state_o = 11 and one done_pulse.
- DONE with BLINK_SECS = 3: matrix_en is high 5 cycles and low 5 cycles, three times, then state_o = 00 and matrix_en = 0; row_idx cycles 0..7 throughout.
- WORK with remain_secs = 5 at tick 4:
  - pause_btn -> state_o = 10, and remain_secs and frame_idx are unchanged for 50 cycles;
  - pause_btn again -> WORK, and the next decrement occurs 5 cycles later.
- IDLE start_btn with cook_secs = 0 or mode_sel = 00 -> state_o stays 00; cancel_btn and pause_btn pulsed in the same cycle during WORK -> IDLE with all outputs 0.
- WORK, with pause_btn coincident with sec_evt -> PAUSE and no decrement; rst driven low mid-WORK -> all outputs 0 asynchronously, and IDLE after release.
